hms_timekeeper: RTL

Parametrised hours/minutes/seconds timekeeper and the next generation of the board's time-of-day counter. It adds a clock-driven prescaler, a configurable hour modulus, a load/hold/run/countdown mode set, an alarm comparator and carry/status pulses. It sits between the board clock and the seven-segment display formatter. User switches drive the mode and load values.

---
 rtl/hms_timekeeper.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hms_timekeeper.sv
// Hours/minutes/seconds timekeeper with prescaler, load/hold/run/countdown modes,
// alarm comparator and one-cycle tick/day-wrap/alarm/timer-done pulses.
module hms_timekeeper #(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned HRS_MOD = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] mode,
  input  logic [4:0] in_hrs,
  input  logic [5:0] in_min,
  input  logic [5:0] in_sec,
  input  logic       alarm_en,
  input  logic [4:0] alm_hrs,
  input  logic [5:0] alm_min,
  input  logic [5:0] alm_sec,
  output logic [4:0] out_hrs,
  output logic [5:0] out_min,
  output logic [5:0] out_sec,
  output logic       tick,
  output logic       day_wrap,
  output logic       alarm_hit,
  output logic       timer_done
);

  localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
  localparam int unsigned PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [4:0] HRS_MAX  = 5'(HRS_MOD - 1);
  localparam logic [5:0] MS_MAX   = 6'd59;

  typedef enum logic [1:0] {
    M_RUN,
    M_LOAD,
    M_HOLD,
    M_CDOWN
  } mode_e;

  mode_e         mode_d;
  logic [PW-1:0] presc;

  logic [4:0] inc_hrs, dec_hrs, ld_hrs;
  logic [5:0] inc_min, dec_min, ld_min;
  logic [5:0] inc_sec, dec_sec, ld_sec;
  logic       at_zero, inc_zero, dec_zero, alarm_match;

  // Codes 4..7 are treated as HOLD
  always_comb begin
    case (mode)
      3'd0:    mode_d = M_RUN;
      3'd1:    mode_d = M_LOAD;
      3'd3:    mode_d = M_CDOWN;
      default: mode_d = M_HOLD;
    endcase
  end

  always_comb begin
    inc_hrs = out_hrs;
    inc_min = out_min;
    inc_sec = out_sec + 6'd1;
    if (out_sec == MS_MAX) begin
      inc_sec = '0;
      if (out_min == MS_MAX) begin
        inc_min = '0;
        inc_hrs = (out_hrs == HRS_MAX) ? '0 : out_hrs + 5'd1;
      end else begin
        inc_min = out_min + 6'd1;
      end
    end
  end

  // Borrow chain; only used when the current value is non-zero
  always_comb begin
    dec_hrs = out_hrs;
    dec_min = out_min;
    dec_sec = out_sec - 6'd1;
    if (out_sec == '0) begin
      dec_sec = MS_MAX;
      if (out_min == '0) begin
        dec_min = MS_MAX;
        dec_hrs = out_hrs - 5'd1;
      end else begin
        dec_min = out_min - 6'd1;
      end
    end
  end

  always_comb begin
    ld_hrs = ({1'b0, in_hrs} >= 6'(HRS_MOD)) ? HRS_MAX : in_hrs;
    ld_min = (in_min > MS_MAX) ? MS_MAX : in_min;
    ld_sec = (in_sec > MS_MAX) ? MS_MAX : in_sec;
  end

  always_comb begin
    at_zero     = (out_hrs == '0) && (out_min == '0) && (out_sec == '0);
    inc_zero    = (inc_hrs == '0) && (inc_min == '0) && (inc_sec == '0);
    dec_zero    = (dec_hrs == '0) && (dec_min == '0) && (dec_sec == '0);
    alarm_match = alarm_en && ({inc_hrs, inc_min, inc_sec} == {alm_hrs, alm_min, alm_sec});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc      <= '0;
      out_hrs    <= '0;
      out_min    <= '0;
      out_sec    <= '0;
      tick       <= 1'b0;
      day_wrap   <= 1'b0;
      alarm_hit  <= 1'b0;
      timer_done <= 1'b0;
    end else begin
      tick       <= 1'b0;
      day_wrap   <= 1'b0;
      alarm_hit  <= 1'b0;
      timer_done <= 1'b0;
      case (mode_d)
        M_LOAD: begin
          presc   <= '0;
          out_hrs <= ld_hrs;
          out_min <= ld_min;
          out_sec <= ld_sec;
        end
        M_RUN, M_CDOWN: begin
          if (presc == PRE_MAX) begin
            presc <= '0;
            tick  <= 1'b1;
            if (mode_d == M_RUN) begin
              out_hrs   <= inc_hrs;
              out_min   <= inc_min;
              out_sec   <= inc_sec;
              day_wrap  <= inc_zero;
              alarm_hit <= alarm_match;
            end else if (!at_zero) begin
              out_hrs    <= dec_hrs;
              out_min    <= dec_min;
              out_sec    <= dec_sec;
              timer_done <= dec_zero;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
